// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register used between the core's stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data
// bundle behind a valid/ready handshake. It supports stall hold and
// flush-to-bubble, and has an optional 2-entry skid buffer. It also keeps
// saturating stall and bubble performance counters.
//
// While the stage holds no valid instruction, out_ctrl always reads
// CTRL_BUBBLE, so no write-enable can leak downstream. out_data keeps its
// last value.
module pipe_stage_reg #(
    parameter int                CTRL_W      = 8,
    parameter int                DATA_W      = 96,
    parameter int                SKID        = 1,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] bubble_cnt
);

    // EMPTY: nothing held. FULL: main register valid.
    // SKID: main and skid entries both valid (reachable only when SKID != 0).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;

    logic acc;
    logic drain;

    assign out_valid = (state_reg != ST_EMPTY);
    assign out_ctrl  = main_ctrl_reg;
    assign out_data  = main_data_reg;

    // A stall from the hazard unit blocks the drain exactly like out_ready=0.
    assign acc   = in_valid & in_ready;
    assign drain = out_valid & out_ready & ~stall;

    // Next-state and register-load decisions; flush overrides everything below reset.
    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;

        case (state_reg)
            ST_EMPTY: begin
                if (acc) begin
                    state_next     = ST_FULL;
                    main_ctrl_next = in_ctrl;
                    main_data_next = in_data;
                end
            end
            ST_FULL: begin
                if (acc && drain) begin
                    main_ctrl_next = in_ctrl;
                    main_data_next = in_data;
                end else if (acc) begin
                    // Downstream is blocked; park the newcomer behind main.
                    // With SKID == 0, in_ready already requires drain, so this
                    // branch is unreachable.
                    state_next     = ST_SKID;
                    skid_ctrl_next = in_ctrl;
                    skid_data_next = in_data;
                end else if (drain) begin
                    state_next     = ST_EMPTY;
                    main_ctrl_next = CTRL_BUBBLE;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only the drain needs handling.
                if (drain) begin
                    state_next     = ST_FULL;
                    main_ctrl_next = skid_ctrl_reg;
                    main_data_next = skid_data_reg;
                    skid_ctrl_next = '0;
                    skid_data_next = '0;
                end
            end
            default: begin
                state_next     = ST_EMPTY;
                main_ctrl_next = CTRL_BUBBLE;
            end
        endcase

        // Squash everything held and anything arriving. The data word keeps
        // its old value because it is don't-care while the stage is empty.
        if (flush) begin
            state_next     = ST_EMPTY;
            main_ctrl_next = CTRL_BUBBLE;
            main_data_next = main_data_reg;
            skid_ctrl_next = '0;
            skid_data_next = '0;
        end
    end

    // State and payload registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_EMPTY;
            main_ctrl_reg <= CTRL_BUBBLE;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic in_ready_reg;

            // Registered ready: low only while both entries are occupied.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_SKID);
                end
            end

            assign in_ready = in_ready_reg;
        end else begin : g_comb_ready
            // Single register: accept when empty or when the held beat leaves now.
            assign in_ready = ~out_valid | drain;
        end
    endgenerate

    // Counter 0 counts held-but-not-drained cycles; counter 1 counts empty cycles.
    logic [1:0] cnt_inc;
    assign cnt_inc[0] = out_valid & ~drain;
    assign cnt_inc[1] = ~out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [PERF_W-1:0] cnt_reg;

            // Saturating event counter; it sticks at all-ones instead of wrapping.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {PERF_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + {{(PERF_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign stall_cnt  = g_perf[0].cnt_reg;
    assign bubble_cnt = g_perf[1].cnt_reg;

endmodule
